// File: rtl/crypto_blk_ctrl.sv
// Register front end and run sequencer for a block cipher core:
// text/state/key storage, lock checks, watchdog and sticky status.
module crypto_blk_ctrl #(
   parameter int BLOCK_WORDS = 4,
   parameter int KEY_WORDS   = 6,
   parameter int NUM_KEYS    = 3,
   parameter int TO_WIDTH    = 16,
   parameter int TO_DEFAULT  = 1024
) (
   input  logic                      clk_i,
   input  logic                      rst_i,
   input  logic [7:0]                reglk_i,
   input  logic                      bus_valid_i,
   input  logic                      bus_write_i,
   input  logic [31:0]               bus_addr_i,
   input  logic [31:0]               bus_wdata_i,
   input  logic [3:0]                bus_wstrb_i,
   output logic [31:0]               bus_rdata_o,
   output logic                      bus_ready_o,
   output logic                      bus_error_o,
   output logic                      core_start_o,
   output logic [32*BLOCK_WORDS-1:0] core_text_o,
   output logic [32*BLOCK_WORDS-1:0] core_state_o,
   output logic [32*KEY_WORDS-1:0]   core_key_o,
   input  logic [32*BLOCK_WORDS-1:0] core_out_i,
   input  logic                      core_out_valid_i,
   output logic                      irq_o
);
   localparam int KSEL_W = (NUM_KEYS > 1) ? $clog2(NUM_KEYS) : 1;

   typedef enum logic [1:0] {IDLE, LAUNCH, RUN} state_t;

   state_t              state, state_nx;
   logic [31:0]         text   [BLOCK_WORDS];
   logic [31:0]         blk    [BLOCK_WORDS];
   logic [31:0]         result [BLOCK_WORDS];
   logic [31:0]         key    [NUM_KEYS][KEY_WORDS];
   logic [KSEL_W-1:0]   ksel, ksel_new;
   logic [TO_WIDTH-1:0] tmo_val, cnt;
   logic                done, tmo, err, busy;
   logic                ready, c_ok, c_bad, c_busy;
   logic [31:0]         widx, rd_val, to_merged;
   logic                is_ctrl, is_stat, is_to, is_text;
   logic                is_blk, is_res, is_key;
   logic                wr_ok, wr_bad, capture, commit;
   logic                launch, fin_ok, fin_to, go, clr;
   logic                addr_unused;

   function automatic logic [31:0] merge(input logic [31:0] old,
                                         input logic [31:0] nw,
                                         input logic [3:0]  be);
      logic [31:0] r;
      for (int b = 0; b < 4; b++)
         r[b*8 +: 8] = be[b] ? nw[b*8 +: 8] : old[b*8 +: 8];
      return r;
   endfunction

   assign widx        = {25'd0, bus_addr_i[8:2]};
   assign addr_unused = ^{bus_addr_i[31:9], bus_addr_i[1:0]};
   assign ksel_new    = bus_wdata_i[8 +: KSEL_W];
   assign go          = bus_wdata_i[0];
   assign clr         = bus_wdata_i[1];
   assign busy        = (state != IDLE);
   assign capture     = bus_valid_i && !ready;
   assign commit      = bus_valid_i && ready;
   assign bus_ready_o = ready;
   assign to_merged   = merge(32'(tmo_val), bus_wdata_i, bus_wstrb_i);

   always_comb begin
      is_ctrl = (widx == 32'd0);
      is_stat = (widx == 32'd1);
      is_to   = (widx == 32'd2);
      is_text = (widx >= 32'd16) && (widx < 32'(16 + BLOCK_WORDS));
      is_blk  = (widx >= 32'd32) && (widx < 32'(32 + BLOCK_WORDS));
      is_res  = (widx >= 32'd48) && (widx < 32'(48 + BLOCK_WORDS));
      is_key  = (widx >= 32'd64)
             && (((widx - 32'd64) >> 3) < 32'(NUM_KEYS))
             && ({29'd0, widx[2:0]} < 32'(KEY_WORDS));
   end

   always_comb begin
      rd_val = '0;
      unique case (1'b1)
         is_ctrl: if (!reglk_i[0]) rd_val[8 +: KSEL_W] = ksel;
         is_stat: if (!reglk_i[6]) rd_val[3:0] = {err, tmo, done, busy};
         is_to:   rd_val[TO_WIDTH-1:0] = tmo_val;
         is_text: if (!reglk_i[2]) begin
            for (int i = 0; i < BLOCK_WORDS; i++)
               if (widx == 32'(16 + i)) rd_val = text[i];
         end
         is_res: if (!reglk_i[4]) begin
            for (int i = 0; i < BLOCK_WORDS; i++)
               if (widx == 32'(48 + i)) rd_val = result[i];
         end
         default: ;
      endcase
   end

   // CTRL while busy is accepted only for its clear bit.
   always_comb begin
      wr_ok  = 1'b0;
      wr_bad = 1'b0;
      if (bus_write_i) begin
         unique case (1'b1)
            is_ctrl: if (!reglk_i[1] && bus_wstrb_i != 4'd0) begin
               wr_ok = 1'b1;
               if (busy) wr_bad = go || (ksel_new != ksel);
               else      wr_bad = go && (32'(ksel_new) >= 32'(NUM_KEYS));
            end
            is_to: wr_ok = !reglk_i[1];
            is_text: if (!reglk_i[3]) begin
               wr_ok  = !busy;
               wr_bad = busy;
            end
            is_blk: if (!reglk_i[7]) begin
               wr_ok  = !busy;
               wr_bad = busy;
            end
            is_key: if (!reglk_i[5]) begin
               wr_ok  = !busy;
               wr_bad = busy;
            end
            default: ;
         endcase
      end
   end

   assign launch = commit && c_ok && is_ctrl && bus_write_i
                && go && !c_busy && !c_bad;
   assign fin_ok = (state == RUN) && core_out_valid_i;
   assign fin_to = (state == RUN) && !core_out_valid_i
                && (tmo_val != '0) && (cnt == tmo_val - TO_WIDTH'(1));

   always_ff @(posedge clk_i) begin
      if (rst_i) state <= IDLE;
      else       state <= state_nx;
   end

   always_comb begin
      state_nx     = state;
      core_start_o = 1'b0;
      unique case (state)
         IDLE:   if (launch) state_nx = LAUNCH;
         LAUNCH: begin
            core_start_o = 1'b1;
            state_nx     = RUN;
         end
         RUN:    if (fin_ok || fin_to) state_nx = IDLE;
         default: state_nx = IDLE;
      endcase
   end

   // Accept decision is taken with ready and applied one edge later.
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         ready       <= 1'b0;
         bus_rdata_o <= '0;
         bus_error_o <= 1'b0;
         c_ok        <= 1'b0;
         c_bad       <= 1'b0;
         c_busy      <= 1'b0;
      end else begin
         ready       <= capture;
         bus_rdata_o <= capture ? rd_val : '0;
         bus_error_o <= capture && wr_bad;
         if (capture) begin
            c_ok   <= wr_ok;
            c_bad  <= wr_bad;
            c_busy <= busy;
         end
      end
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         for (int i = 0; i < BLOCK_WORDS; i++) begin
            text[i]   <= '0;
            blk[i]    <= '0;
            result[i] <= '0;
         end
         for (int k = 0; k < NUM_KEYS; k++)
            for (int w = 0; w < KEY_WORDS; w++)
               key[k][w] <= '0;
         ksel    <= '0;
         tmo_val <= TO_WIDTH'(TO_DEFAULT);
         cnt     <= '0;
         done    <= 1'b0;
         tmo     <= 1'b0;
         err     <= 1'b0;
         irq_o   <= 1'b0;
      end else begin
         irq_o <= fin_ok || fin_to;
         if (state == LAUNCH)   cnt <= '0;
         else if (state == RUN) cnt <= cnt + TO_WIDTH'(1);
         if (commit && c_ok) begin
            if (is_ctrl) begin
               if (clr) begin
                  err <= 1'b0;
                  if (!c_busy) begin
                     done <= 1'b0;
                     tmo  <= 1'b0;
                  end
               end
               if (!c_busy) ksel <= ksel_new;
            end
            if (is_to) tmo_val <= to_merged[TO_WIDTH-1:0];
            for (int i = 0; i < BLOCK_WORDS; i++) begin
               if (is_text && widx == 32'(16 + i))
                  text[i] <= merge(text[i], bus_wdata_i, bus_wstrb_i);
               if (is_blk && widx == 32'(32 + i))
                  blk[i] <= merge(blk[i], bus_wdata_i, bus_wstrb_i);
            end
            for (int k = 0; k < NUM_KEYS; k++)
               for (int w = 0; w < KEY_WORDS; w++)
                  if (is_key && widx == 32'(64 + k*8 + w))
                     key[k][w] <= merge(key[k][w], bus_wdata_i, bus_wstrb_i);
         end
         if (launch) begin
            done <= 1'b0;
            tmo  <= 1'b0;
         end
         if (fin_ok) begin
            done <= 1'b1;
            for (int i = 0; i < BLOCK_WORDS; i++)
               result[i] <= core_out_i[i*32 +: 32];
         end
         if (fin_to) tmo <= 1'b1;
         if (commit && c_bad) err <= 1'b1;
      end
   end

   always_comb begin
      core_text_o  = '0;
      core_state_o = '0;
      for (int i = 0; i < BLOCK_WORDS; i++) begin
         core_text_o[i*32 +: 32]  = text[i];
         core_state_o[i*32 +: 32] = blk[i];
      end
   end

   always_comb begin
      core_key_o = '0;
      for (int k = 0; k < NUM_KEYS; k++)
         if (32'(ksel) == 32'(k))
            for (int w = 0; w < KEY_WORDS; w++)
               core_key_o[w*32 +: 32] = key[k][w];
   end
endmodule
